light_sequencer: RTL and testbench

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

---
 rtl/light_sequencer.sv | 66 ++++++
 tb/tb_light_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/light_sequencer.sv
// light_sequencer: two-road traffic light FSM driving an external 6-bit up-counter for phase timing.
module light_sequencer #(
    parameter int GREEN_T  = 30,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_i,
    input  logic [5:0] count_i,
    output logic       load_o,
    output logic [5:0] value_o,
    output logic [2:0] main_o,
    output logic [2:0] side_o,
    output logic [2:0] state_o
);
    localparam logic [2:0] MAIN_G = 3'd0;
    localparam logic [2:0] MAIN_Y = 3'd1;
    localparam logic [2:0] ALLR1  = 3'd2;
    localparam logic [2:0] SIDE_G = 3'd3;
    localparam logic [2:0] SIDE_Y = 3'd4;
    localparam logic [2:0] ALLR2  = 3'd5;
    localparam logic [2:0] LT_R   = 3'b100;
    localparam logic [2:0] LT_Y   = 3'b010;
    localparam logic [2:0] LT_G   = 3'b001;

    logic [2:0] state, state_nx;
    logic       req, start, term;

    // counter preload so that the phase ends when the counter reaches 63
    function automatic logic [5:0] load_val(input logic [2:0] s);
        load_val = (s == MAIN_Y || s == SIDE_Y) ? 6'(64 - YELLOW_T) :
                   (s == ALLR1 || s == ALLR2)   ? 6'(64 - ALLRED_T) :
                                                  6'(64 - GREEN_T);
    endfunction

    assign term    = count_i == 6'd63;
    assign load_o  = term | start;
    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MAIN_G;
            req   <= 1'b0;
            start <= 1'b1;
        end else begin
            state <= state_nx;
            start <= 1'b0;
            req   <= (state_nx == SIDE_G && state != SIDE_G) ? 1'b0 : req | car_i;
        end
    end

    always_comb begin
        state_nx = (start || state > ALLR2) ? MAIN_G :
                   !term                    ? state :
                   (state == MAIN_G)        ? (req ? MAIN_Y : MAIN_G) :
                   (state == ALLR2)         ? MAIN_G :
                                              state + 3'd1;
    end

    always_comb begin
        main_o  = (state == MAIN_G) ? LT_G : (state == MAIN_Y) ? LT_Y : LT_R;
        side_o  = (state == SIDE_G) ? LT_G : (state == SIDE_Y) ? LT_Y : LT_R;
        value_o = load_val(load_o ? state_nx : state);
    end
endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: vector table, forced-counter corner cases and randomized run against a phase-level model.
module tb_light_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car = 1'b0;
    logic       force_en = 1'b1;
    logic [5:0] force_val = 6'd10;
    logic [5:0] cnt0 = 6'd0, cnt1 = 6'd0;
    logic [5:0] count0;
    logic       load0, load1;
    logic [5:0] val0, val1;
    logic [2:0] main0, main1, side0, side1, st0, st1;
    int         npass = 0, ntot = 0;

    always #5 clk = ~clk;

    assign count0 = force_en ? force_val : cnt0;

    light_sequencer dut (
        .clk(clk), .rst_n(rst_n), .car_i(car), .count_i(count0),
        .load_o(load0), .value_o(val0), .main_o(main0), .side_o(side0), .state_o(st0)
    );

    light_sequencer #(.GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .car_i(car), .count_i(cnt1),
        .load_o(load1), .value_o(val1), .main_o(main1), .side_o(side1), .state_o(st1)
    );

    // external up-counters
    always @(posedge clk) begin
        cnt0 <= load0 ? val0 : cnt0 + 6'd1;
        cnt1 <= load1 ? val1 : cnt1 + 6'd1;
    end

    // phase-level reference model: phase index, cycles elapsed, pending request
    int gt[2] = '{30, 1};
    int yt[2] = '{5, 1};
    int at[2] = '{2, 1};
    int p[2], e[2];
    bit r[2], first[2];

    function automatic int plen(int k, int ph);
        return (ph == 1 || ph == 4) ? yt[k] : (ph == 2 || ph == 5) ? at[k] : gt[k];
    endfunction

    function automatic bit ending(int k);
        return first[k] || (e[k] + 1 >= plen(k, p[k]));
    endfunction

    function automatic int next_phase(int k);
        if (first[k] || !ending(k)) return p[k];
        if (p[k] == 0 && !r[k]) return 0;
        return (p[k] + 1) % 6;
    endfunction

    function automatic logic [15:0] expect_out(int k);
        logic [2:0] m, s;
        logic [5:0] v;
        m = (p[k] == 0) ? 3'b001 : (p[k] == 1) ? 3'b010 : 3'b100;
        s = (p[k] == 3) ? 3'b001 : (p[k] == 4) ? 3'b010 : 3'b100;
        v = ending(k) ? 6'(64 - plen(k, next_phase(k))) : 6'(64 - plen(k, p[k]));
        return {3'(p[k]), m, s, ending(k), v};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                p[k] = 0; e[k] = 0; r[k] = 1'b0; first[k] = 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int  np;
                bit  en, entering;
                np       = next_phase(k);
                en       = ending(k);
                entering = !first[k] && en && p[k] == 2;
                e[k]     = en ? 0 : e[k] + 1;
                r[k]     = entering ? 1'b0 : (r[k] | car);
                p[k]     = np;
                first[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_models();
        chk("model0", {st0, main0, side0, load0, val0}, expect_out(0));
        chk("model1", {st1, main1, side1, load1, val1}, expect_out(1));
    endtask

    task automatic step(input logic c, input logic rel);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        car = c;
        #1;
        chk_models();
    endtask

    typedef struct {
        logic [5:0] cnt;
        logic       car;
        logic       ld;
        logic [5:0] val;
        logic [2:0] st;
        logic [2:0] mn;
        logic [2:0] sd;
    } vec_t;
    vec_t tbl[14];

    initial begin
        bit found;
        tbl[0]  = '{6'd10, 1'b0, 1'b1, 6'd34, 3'd0, 3'b001, 3'b100};
        tbl[1]  = '{6'd10, 1'b0, 1'b0, 6'd34, 3'd0, 3'b001, 3'b100};
        tbl[2]  = '{6'd63, 1'b0, 1'b1, 6'd34, 3'd0, 3'b001, 3'b100};
        tbl[3]  = '{6'd62, 1'b1, 1'b0, 6'd34, 3'd0, 3'b001, 3'b100};
        tbl[4]  = '{6'd63, 1'b0, 1'b1, 6'd59, 3'd0, 3'b001, 3'b100};
        tbl[5]  = '{6'd5,  1'b0, 1'b0, 6'd59, 3'd1, 3'b010, 3'b100};
        tbl[6]  = '{6'd63, 1'b0, 1'b1, 6'd62, 3'd1, 3'b010, 3'b100};
        tbl[7]  = '{6'd63, 1'b1, 1'b1, 6'd34, 3'd2, 3'b100, 3'b100};
        tbl[8]  = '{6'd0,  1'b0, 1'b0, 6'd34, 3'd3, 3'b100, 3'b001};
        tbl[9]  = '{6'd63, 1'b0, 1'b1, 6'd59, 3'd3, 3'b100, 3'b001};
        tbl[10] = '{6'd63, 1'b0, 1'b1, 6'd62, 3'd4, 3'b100, 3'b010};
        tbl[11] = '{6'd63, 1'b0, 1'b1, 6'd34, 3'd5, 3'b100, 3'b100};
        tbl[12] = '{6'd63, 1'b0, 1'b1, 6'd34, 3'd0, 3'b001, 3'b100};
        tbl[13] = '{6'd0,  1'b0, 1'b0, 6'd34, 3'd0, 3'b001, 3'b100};

        // table phase: counter driven directly by the bench
        repeat (3) @(negedge clk);
        #1 chk("reset_hold", {st0, main0, side0, load0, val0}, {3'd0, 3'b001, 3'b100, 1'b1, 6'd34});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            force_val = tbl[i].cnt;
            car = tbl[i].car;
            #1;
            chk($sformatf("vec%0d", i), {st0, main0, side0, load0, val0},
                {tbl[i].st, tbl[i].mn, tbl[i].sd, tbl[i].ld, tbl[i].val});
        end

        // stuck counter value never reaching 63: no transition, no load
        @(negedge clk);
        rst_n = 1'b0;
        force_val = 6'd10;
        car = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("stuck_start", {st0, load0, val0}, {3'd0, 1'b1, 6'd34});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1 chk("stuck_hold", {st0, main0, side0, load0, val0}, {3'd0, 3'b001, 3'b100, 1'b0, 6'd34});
        end

        // model-checked run with the real counter
        @(negedge clk);
        rst_n = 1'b0;
        force_en = 1'b0;
        @(negedge clk);
        #1 chk_models();
        step(1'b0, 1'b1);
        repeat (100) step(1'b0, 1'b0);
        repeat (200) step(1'b1, 1'b0);
        repeat (1200) step(1'($urandom_range(0, 19) == 0), 1'b0);

        // asynchronous reset in the middle of a SIDE_Y cycle
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b1, 1'b0);
            found = st0 == 3'd4;
        end
        chk("reach_side_y", {15'd0, found}, 16'd1);
        car = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {st0, main0, side0, load0, val0}, {3'd0, 3'b001, 3'b100, 1'b1, 6'd34});
        chk_models();
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (60) step(1'b0, 1'b0);
        repeat (300) step(1'($urandom_range(0, 9) == 0), 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
